// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state type, REST code and note encode/decode
// helpers for the record/playback sequencer.
package note_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY
  } state_t;

  localparam int CODE_W = 4;
  localparam logic [CODE_W-1:0] REST = 4'hF;

  // Widest keyboard a 4-bit code can address (code F is REST).
  localparam int KEYS_MAX = 15;

  // Lowest pressed key wins; no key pressed encodes REST.
  function automatic logic [CODE_W-1:0] enc(
    input logic [KEYS_MAX-1:0] v
  );
    logic [CODE_W-1:0] c;
    c = REST;
    for (int i = KEYS_MAX - 1; i >= 0; i--) begin
      if (v[i]) c = CODE_W'(i);
    end
    return c;
  endfunction

  // One-hot of the code; REST gives an all-zero vector.
  function automatic logic [KEYS_MAX-1:0] dec(
    input logic [CODE_W-1:0] c
  );
    logic [KEYS_MAX-1:0] d;
    d = '0;
    if (c != REST) d[c] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/note_seq_buffer.sv
// note_seq_buffer: DEPTH x W entry store, sync write, comb read.
// Ports: clk, wr_en/wr_addr/wr_data write port, rd_addr/rd_data read.
module note_seq_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  // Contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: live pass-through, record of (note, ticks) entries,
// playback as one-hot keys. Ports: clk, rst_n, keys_in, rec_start,
// play_start, stop -> keys_out, recording, playing, full, count.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int NKEYS = 11,
  parameter int DEPTH = 16,
  parameter int DURW  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NKEYS-1:0]         keys_in,
  input  logic                     rec_start,
  input  logic                     play_start,
  input  logic                     stop,
  output logic [NKEYS-1:0]         keys_out,
  output logic                     recording,
  output logic                     playing,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = CODE_W + DURW;

  localparam logic [DURW-1:0] DUR_MAX = '1;
  localparam logic [DURW-1:0] DUR_ONE = DURW'(1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [CW-1:0]   CNT_TOP = CW'(DEPTH);

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [DURW-1:0]   dur;
  } entry_t;

  state_t            state_q, state_d;
  logic [NKEYS-1:0]  keys_out_q, keys_out_d;
  logic              recording_q, recording_d;
  logic              playing_q, playing_d;
  logic              full_q, full_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CODE_W-1:0] cur_q, cur_d;
  logic [DURW-1:0]   dur_q, dur_d;
  logic [DURW-1:0]   remain_q, remain_d;
  logic [CW-1:0]     rd_q, rd_d;

  logic              wr_en;
  logic [EW-1:0]     wr_data;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_data;
  entry_t            wr_ent;
  entry_t            rd_ent;
  logic [CODE_W-1:0] code_in;
  logic [NKEYS-1:0]  rd_keys;

  assign code_in = enc(KEYS_MAX'(keys_in));
  assign rd_ent  = rd_data;
  assign rd_keys = NKEYS'(dec(rd_ent.code));
  assign wr_ent  = '{code: cur_q, dur: dur_q};
  assign wr_data = wr_ent;

  // Outside PLAY the read port sits on entry 0 so play_start
  // can load it on the same edge.
  assign rd_addr = (state_q == PLAY) ? rd_q[AW-1:0] : '0;

  note_seq_buffer #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    keys_out_d = keys_out_q;
    full_d     = full_q;
    count_d    = count_q;
    cur_d      = cur_q;
    dur_d      = dur_q;
    remain_d   = remain_q;
    rd_d       = rd_q;
    wr_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        keys_out_d = keys_in;
        if (rec_start) begin
          count_d = '0;
          full_d  = 1'b0;
          cur_d   = code_in;
          dur_d   = DUR_ONE;
          state_d = RECORD;
        end else if (play_start && count_q != '0) begin
          keys_out_d = rd_keys;
          remain_d   = rd_ent.dur;
          rd_d       = CNT_ONE;
          state_d    = PLAY;
        end
      end

      RECORD: begin
        keys_out_d = keys_in;
        if (stop) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end else if (code_in != cur_q) begin
          wr_en = 1'b1;
          cur_d = code_in;
          dur_d = DUR_ONE;
        end else if (dur_q == DUR_MAX) begin
          // Long note: close this entry, continue in a fresh one.
          wr_en = 1'b1;
          dur_d = DUR_ONE;
        end else begin
          dur_d = dur_q + DUR_ONE;
        end
        if (wr_en) begin
          count_d = count_q + CNT_ONE;
          if (count_d == CNT_TOP) begin
            full_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      PLAY: begin
        if (stop) begin
          keys_out_d = keys_in;
          state_d    = IDLE;
        end else if (remain_q > DUR_ONE) begin
          remain_d = remain_q - DUR_ONE;
        end else if (rd_q < count_q) begin
          keys_out_d = rd_keys;
          remain_d   = rd_ent.dur;
          rd_d       = rd_q + CNT_ONE;
        end else begin
          keys_out_d = keys_in;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    recording_d = (state_d == RECORD);
    playing_d   = (state_d == PLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      keys_out_q  <= '0;
      recording_q <= 1'b0;
      playing_q   <= 1'b0;
      full_q      <= 1'b0;
      count_q     <= '0;
      cur_q       <= '0;
      dur_q       <= '0;
      remain_q    <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      keys_out_q  <= keys_out_d;
      recording_q <= recording_d;
      playing_q   <= playing_d;
      full_q      <= full_d;
      count_q     <= count_d;
      cur_q       <= cur_d;
      dur_q       <= dur_d;
      remain_q    <= remain_d;
      rd_q        <= rd_d;
    end
  end

  assign keys_out  = keys_out_q;
  assign recording = recording_q;
  assign playing   = playing_q;
  assign full      = full_q;
  assign count     = count_q;

endmodule
